inst_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the synchronous instruction ROM. It owns the program counter, drives the ROM word address, captures the returned instruction word with its PC into a 2-entry skid FIFO, and presents PC/instruction pairs to decode over a valid/ready handshake. It also applies MIPS-style delayed redirects (branch/jump, delay slot preserved) and immediate flushes.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_skid_fifo.sv | 79 +++++++
 rtl/inst_fetch_unit.sv | 108 ++++++++++
 tb/tb_inst_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and FIFO entry type for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_AW       = 30;
  localparam logic [1:0]  FIFO_DEPTH       = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO between the ROM capture point and decode.
// Head entry and valid are registered; a clear drops all entries at the next edge.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop_ready,
  output logic         full,
  output logic         out_valid,
  output fetch_entry_t out_data
);

  logic [1:0]   count_r;
  logic [1:0]   count_nxt_s;
  logic         valid_r;
  logic         do_push_s;
  logic         do_pop_s;
  fetch_entry_t head_r;
  fetch_entry_t tail_r;
  fetch_entry_t head_nxt_s;
  fetch_entry_t tail_nxt_s;

  // Next occupancy and slot contents from the push/pop combination
  always_comb begin
    do_push_s   = push && (count_r != FIFO_DEPTH);
    do_pop_s    = pop_ready && valid_r;
    count_nxt_s = count_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    case ({do_push_s, do_pop_s})
      2'b10: begin
        count_nxt_s = count_r + 2'd1;
        if (count_r == 2'd0) begin
          head_nxt_s = push_data;
        end else begin
          tail_nxt_s = push_data;
        end
      end
      2'b01: begin
        count_nxt_s = count_r - 2'd1;
        if (count_r == FIFO_DEPTH) begin
          head_nxt_s = tail_r;
        end else begin
          head_nxt_s = head_r;
        end
      end
      // Simultaneous push and pop can only happen with one entry held
      2'b11: head_nxt_s = push_data;
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy, valid flag and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 2'd0;
      valid_r <= 1'b0;
      head_r  <= '0;
      tail_r  <= '0;
    end else if (clear) begin
      count_r <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != 2'd0);
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
    end
  end

  assign full      = (count_r == FIFO_DEPTH);
  assign out_valid = valid_r;
  assign out_data  = head_r;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, addresses the synchronous ROM, applies delayed
// redirects and flushes, and queues PC/instruction pairs for decode.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned AW       = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_inst,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_target,
  input  logic          flush,
  input  logic [31:0]   flush_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst
);

  localparam logic [AW-1:0] RESET_WORD = RESET_PC[AW+1:2];
  localparam logic [AW-1:0] WORD_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] pc_f_r;
  logic [AW-1:0] rd_tgt_r;
  logic [AW-1:0] redir_tgt_s;
  logic [AW-1:0] addr_s;
  logic          f_valid_r;
  logic          rd_pend_r;
  logic          fifo_full_s;
  logic          accept_s;
  logic          redir_hit_s;
  logic          push_s;
  fetch_entry_t  push_data_s;
  fetch_entry_t  head_s;
  logic          unused_s;

  // Next ROM address; accept depends only on registered state so decode
  // backpressure never reaches the ROM address path.
  always_comb begin
    accept_s    = f_valid_r && !fifo_full_s;
    redir_hit_s = redirect_valid || rd_pend_r;
    redir_tgt_s = rd_tgt_r;
    addr_s      = pc_f_r;
    push_s      = accept_s && !flush;
    if (redirect_valid) begin
      redir_tgt_s = redirect_target[AW+1:2];
    end else begin
      redir_tgt_s = rd_tgt_r;
    end
    if (flush) begin
      addr_s = flush_target[AW+1:2];
    end else if (accept_s && redir_hit_s) begin
      addr_s = redir_tgt_s;
    end else if (accept_s) begin
      addr_s = pc_f_r + WORD_ONE;
    end else begin
      addr_s = pc_f_r;
    end
  end

  // PC of the presented word, ROM-valid flag and the pending redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_r    <= RESET_WORD;
      f_valid_r <= 1'b0;
      rd_pend_r <= 1'b0;
      rd_tgt_r  <= '0;
    end else if (flush) begin
      pc_f_r    <= flush_target[AW+1:2];
      f_valid_r <= 1'b1;
      rd_pend_r <= 1'b0;
    end else begin
      f_valid_r <= 1'b1;
      if (accept_s) begin
        pc_f_r    <= addr_s;
        rd_pend_r <= 1'b0;
      end else if (redirect_valid) begin
        rd_pend_r <= 1'b1;
        rd_tgt_r  <= redirect_target[AW+1:2];
      end else begin
        rd_pend_r <= rd_pend_r;
      end
    end
  end

  assign push_data_s = {32'({pc_f_r, 2'b00}), imem_inst};
  assign unused_s    = ^{redirect_target[1:0], flush_target[1:0]};

  fetch_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (push_s),
    .push_data (push_data_s),
    .pop_ready (out_ready),
    .full      (fifo_full_s),
    .out_valid (out_valid),
    .out_data  (head_s)
  );

  assign imem_addr = addr_s;
  assign out_pc    = head_s.pc;
  assign out_inst  = head_s.inst;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a ROM model returning 0x1000_0000 + word address.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        flush;
  logic [31:0] flush_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  logic [31:0] exp_pc;
  logic [31:0] slot_pc;
  logic [31:0] jump_pc;

  inst_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_inst       (imem_inst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .flush           (flush),
    .flush_target    (flush_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: registers the address, data valid the next cycle
  always @(posedge clk) imem_inst <= 32'h1000_0000 + {2'b00, imem_addr};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0;
    flush = 1'b0; flush_target = 32'd0;
    step(); step(); step();
    n_checks++; if (imem_addr !== 30'd0) begin n_fail++; $display("FAIL reset_addr: got %h, expected %h", imem_addr, 30'd0); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    n_checks++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h, expected 0", out_pc); end
    n_checks++; if (out_inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %h, expected 0", out_inst); end
    rst_n = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL edge1_valid: got %b, expected 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL edge2_valid: got %b, expected 1", out_valid); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL edge2_pc: got %h, expected 0", out_pc); end
    n_checks++; if (out_inst !== 32'h1000_0000) begin n_fail++; $display("FAIL edge2_inst: got %h, expected 10000000", out_inst); end
  endtask

  task automatic test_stream;
    exp_pc = 32'h0; slot_pc = 32'h1; jump_pc = 32'h0; n_xfer = 0;
    for (int c = 0; c < 10 && n_xfer < 3; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== 32'h1000_0000 + (exp_pc >> 2)) begin
          n_fail++;
          $display("FAIL stream_xfer: got pc=%h inst=%h, expected pc=%h inst=%h", out_pc, out_inst, exp_pc, 32'h1000_0000 + (exp_pc >> 2));
        end
        n_xfer++;
        exp_pc = (exp_pc == slot_pc) ? jump_pc : exp_pc + 32'd4;
      end
      step();
    end
    n_checks++; if (n_xfer != 3) begin n_fail++; $display("FAIL stream_count: got %0d, expected 3", n_xfer); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0000_000C) begin
        n_fail++;
        $display("FAIL stall_hold: got valid=%b pc=%h, expected valid=1 pc=0000000c", out_valid, out_pc);
      end
    end
    n_checks++; if (imem_addr !== 30'd5) begin n_fail++; $display("FAIL stall_addr: got %h, expected %h", imem_addr, 30'd5); end
    out_ready = 1'b1; n_xfer = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== 32'h1000_0000 + (exp_pc >> 2)) begin
          n_fail++;
          $display("FAIL release_xfer: got pc=%h inst=%h, expected pc=%h inst=%h", out_pc, out_inst, exp_pc, 32'h1000_0000 + (exp_pc >> 2));
        end
        n_xfer++;
        exp_pc = (exp_pc == slot_pc) ? jump_pc : exp_pc + 32'd4;
      end
      step();
    end
    n_checks++; if (n_xfer != 4) begin n_fail++; $display("FAIL release_count: got %0d, expected 4", n_xfer); end
  endtask

  task automatic test_redirect;
    slot_pc = 32'h20; jump_pc = 32'h100;
    for (int c = 0; c < 20 && imem_addr !== 30'd9; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== 32'h1000_0000 + (exp_pc >> 2)) begin
          n_fail++;
          $display("FAIL redir_pre_xfer: got pc=%h inst=%h, expected pc=%h", out_pc, out_inst, exp_pc);
        end
        exp_pc = (exp_pc == slot_pc) ? jump_pc : exp_pc + 32'd4;
      end
      step();
    end
    n_checks++; if (imem_addr !== 30'd9) begin n_fail++; $display("FAIL redir_sync: got %h, expected %h", imem_addr, 30'd9); end
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    #1;
    n_checks++; if (imem_addr !== 30'h40) begin n_fail++; $display("FAIL redir_addr: got %h, expected %h", imem_addr, 30'h40); end
    n_xfer = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== 32'h1000_0000 + (exp_pc >> 2)) begin
          n_fail++;
          $display("FAIL redir_xfer: got pc=%h inst=%h, expected pc=%h inst=%h", out_pc, out_inst, exp_pc, 32'h1000_0000 + (exp_pc >> 2));
        end
        n_xfer++;
        exp_pc = (exp_pc == slot_pc) ? jump_pc : exp_pc + 32'd4;
      end
      step();
      redirect_valid = 1'b0;
    end
    n_checks++; if (n_xfer != 6) begin n_fail++; $display("FAIL redir_count: got %0d, expected 6", n_xfer); end
  endtask

  task automatic test_redirect_pending;
    slot_pc = 32'h120; jump_pc = 32'h200;
    for (int c = 0; c < 20 && imem_addr !== 30'h48; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== 32'h1000_0000 + (exp_pc >> 2)) begin
          n_fail++;
          $display("FAIL pend_pre_xfer: got pc=%h inst=%h, expected pc=%h", out_pc, out_inst, exp_pc);
        end
        exp_pc = (exp_pc == slot_pc) ? jump_pc : exp_pc + 32'd4;
      end
      step();
    end
    n_checks++; if (imem_addr !== 30'h48) begin n_fail++; $display("FAIL pend_sync: got %h, expected %h", imem_addr, 30'h48); end
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    #1;
    n_checks++; if (imem_addr !== 30'h48) begin n_fail++; $display("FAIL pend_hold1: got %h, expected %h", imem_addr, 30'h48); end
    step(); redirect_valid = 1'b0; step();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
    #1;
    n_checks++; if (imem_addr !== 30'h48) begin n_fail++; $display("FAIL pend_hold2: got %h, expected %h", imem_addr, 30'h48); end
    step(); redirect_valid = 1'b0;
    out_ready = 1'b1; n_xfer = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== 32'h1000_0000 + (exp_pc >> 2)) begin
          n_fail++;
          $display("FAIL pend_xfer: got pc=%h inst=%h, expected pc=%h inst=%h", out_pc, out_inst, exp_pc, 32'h1000_0000 + (exp_pc >> 2));
        end
        n_xfer++;
        exp_pc = (exp_pc == slot_pc) ? jump_pc : exp_pc + 32'd4;
      end
      step();
    end
    n_checks++; if (n_xfer != 6) begin n_fail++; $display("FAIL pend_count: got %0d, expected 6", n_xfer); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    step(); step(); step();
    flush = 1'b1; flush_target = 32'h0000_0080;
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    #1;
    n_checks++; if (imem_addr !== 30'h20) begin n_fail++; $display("FAIL flush_addr: got %h, expected %h", imem_addr, 30'h20); end
    step();
    flush = 1'b0; redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, expected 0", out_valid); end
    out_ready = 1'b1; exp_pc = 32'h80; slot_pc = 32'h1; n_xfer = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== 32'h1000_0000 + (exp_pc >> 2)) begin
          n_fail++;
          $display("FAIL flush_xfer: got pc=%h inst=%h, expected pc=%h inst=%h", out_pc, out_inst, exp_pc, 32'h1000_0000 + (exp_pc >> 2));
        end
        n_xfer++;
        exp_pc = (exp_pc == slot_pc) ? jump_pc : exp_pc + 32'd4;
      end
      step();
    end
    n_checks++; if (n_xfer < 4) begin n_fail++; $display("FAIL flush_count: got %0d, expected at least 4", n_xfer); end
  endtask

  task automatic test_wrap;
    flush = 1'b1; flush_target = 32'hFFFF_FFF8;
    step();
    flush = 1'b0;
    exp_pc = 32'hFFFF_FFF8; slot_pc = 32'h1; n_xfer = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== 32'h1000_0000 + (exp_pc >> 2)) begin
          n_fail++;
          $display("FAIL wrap_xfer: got pc=%h inst=%h, expected pc=%h inst=%h", out_pc, out_inst, exp_pc, 32'h1000_0000 + (exp_pc >> 2));
        end
        n_xfer++;
        exp_pc = (exp_pc == slot_pc) ? jump_pc : exp_pc + 32'd4;
      end
      step();
    end
    n_checks++; if (n_xfer < 6) begin n_fail++; $display("FAIL wrap_count: got %0d, expected at least 6", n_xfer); end
  endtask

  task automatic test_async_reset;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b, expected 0", out_valid); end
    n_checks++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL areset_pc: got %h, expected 0", out_pc); end
    n_checks++; if (out_inst !== 32'd0) begin n_fail++; $display("FAIL areset_inst: got %h, expected 0", out_inst); end
    n_checks++; if (imem_addr !== 30'd0) begin n_fail++; $display("FAIL areset_addr: got %h, expected %h", imem_addr, 30'd0); end
    step();
    rst_n = 1'b1;
    exp_pc = 32'h0; slot_pc = 32'h1; n_xfer = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== 32'h1000_0000 + (exp_pc >> 2)) begin
          n_fail++;
          $display("FAIL restart_xfer: got pc=%h inst=%h, expected pc=%h inst=%h", out_pc, out_inst, exp_pc, 32'h1000_0000 + (exp_pc >> 2));
        end
        n_xfer++;
        exp_pc = (exp_pc == slot_pc) ? jump_pc : exp_pc + 32'd4;
      end
      step();
    end
    n_checks++; if (n_xfer < 3) begin n_fail++; $display("FAIL restart_count: got %0d, expected at least 3", n_xfer); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pending();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
